// File: rtl/plateau_detector_gen.sv
// Plateau detector: finds runs of plateau_len samples above threshold, tracks the peak
// with an edge-hold freeze and emits one {peak_offset, peak_phase, peak_metric} beat per burst.
module plateau_detector_gen #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned EDGE_HOLD   = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic [WIDTH-1:0]                       threshold,
  input  logic [CNT_WIDTH-1:0]                   plateau_len,
  input  logic [PHASE_WIDTH+WIDTH-1:0]           i_tdata,
  input  logic                                   i_tlast,
  input  logic                                   i_tvalid,
  output logic                                   i_tready,
  output logic [CNT_WIDTH+PHASE_WIDTH+WIDTH-1:0] o_tdata,
  output logic                                   o_tlast,
  output logic                                   o_tvalid,
  input  logic                                   o_tready
);
  localparam logic [CNT_WIDTH-1:0] EDGE_LIM = CNT_WIDTH'(EDGE_HOLD);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RISE, HOLD, WAIT_LOW} state_t;

  state_t                 state, nxt_state;
  logic [CNT_WIDTH-1:0]   run_cnt, edge_cnt, peak_idx;
  logic [CNT_WIDTH-1:0]   nxt_run, nxt_edge, nxt_idx;
  logic [CNT_WIDTH-1:0]   run_inc, edge_inc, plen;
  logic [WIDTH-1:0]       peak, nxt_peak, metric;
  logic [PHASE_WIDTH-1:0] peak_phase, nxt_phase, phase;
  logic                   accept, above, report;

  assign metric   = i_tdata[WIDTH-1:0];
  assign phase    = i_tdata[PHASE_WIDTH+WIDTH-1:WIDTH];
  assign i_tready = ~o_tvalid | o_tready;
  assign o_tlast  = 1'b1;
  assign accept   = i_tvalid & i_tready;
  assign above    = metric > threshold;
  assign plen     = (plateau_len == '0) ? ONE : plateau_len;
  assign run_inc  = (run_cnt == '1) ? run_cnt : run_cnt + ONE;
  assign edge_inc = (edge_cnt == '1) ? edge_cnt : edge_cnt + ONE;

  always_comb begin
    nxt_state = state;
    nxt_run   = run_cnt;
    nxt_edge  = edge_cnt;
    nxt_idx   = peak_idx;
    nxt_peak  = peak;
    nxt_phase = peak_phase;
    report    = 1'b0;
    case (state)
      IDLE: begin
        if (above) begin
          nxt_state = RISE;
          nxt_run   = ONE;
          nxt_edge  = '0;
          nxt_idx   = '0;
          nxt_peak  = metric;
          nxt_phase = phase;
          report    = (plen == ONE);
        end
      end
      RISE: begin
        if (above) begin
          nxt_run = run_inc;
          if (metric > peak) begin
            nxt_peak  = metric;
            nxt_phase = phase;
            nxt_idx   = run_cnt;
            nxt_edge  = '0;
          end else begin
            nxt_edge = edge_inc;
          end
          if (run_inc == plen) report = 1'b1;
          else if (nxt_edge >= EDGE_LIM) nxt_state = HOLD;
        end else begin
          nxt_state = IDLE;
        end
      end
      HOLD: begin
        // Frozen peak still reports once the run reaches the required length.
        if (above) begin
          nxt_run = run_inc;
          report  = (run_inc == plen);
        end else begin
          nxt_state = IDLE;
        end
      end
      WAIT_LOW: if (!above) nxt_state = IDLE;
      default:  nxt_state = IDLE;
    endcase
    if (report)  nxt_state = WAIT_LOW;
    if (i_tlast) nxt_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run_cnt    <= '0;
      edge_cnt   <= '0;
      peak_idx   <= '0;
      peak       <= '0;
      peak_phase <= '0;
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
    end else if (clear) begin
      state      <= IDLE;
      run_cnt    <= '0;
      edge_cnt   <= '0;
      peak_idx   <= '0;
      peak       <= '0;
      peak_phase <= '0;
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
    end else begin
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;
      if (accept) begin
        state      <= nxt_state;
        run_cnt    <= nxt_run;
        edge_cnt   <= nxt_edge;
        peak_idx   <= nxt_idx;
        peak       <= nxt_peak;
        peak_phase <= nxt_phase;
        if (report) begin
          o_tvalid <= 1'b1;
          o_tdata  <= {nxt_idx, nxt_phase, nxt_peak};
        end
      end
    end
  end
endmodule

// File: tb/tb_plateau_detector_gen.sv
// Directed vector bench for plateau_detector_gen: per-sample tables of expected
// descriptor outputs plus hand sequences for backpressure, clear and reset.
module tb_plateau_detector_gen;
  localparam int unsigned W  = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 16;

  logic             clk = 1'b0;
  logic             reset, clear;
  logic [W-1:0]     threshold;
  logic [CW-1:0]    plateau_len;
  logic [PW+W-1:0]  i_tdata;
  logic             i_tlast, i_tvalid, i_tready;
  logic [CW+PW+W-1:0] o_tdata;
  logic             o_tlast, o_tvalid, o_tready;

  plateau_detector_gen #(.WIDTH(W), .PHASE_WIDTH(PW), .CNT_WIDTH(CW), .EDGE_HOLD(5)) dut (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
    .plateau_len(plateau_len), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]       metric;
    logic [PW-1:0]      phase;
    logic               last;
    logic               ev;
    logic [CW+PW+W-1:0] ed;
  } vec_t;

  vec_t vq[$];
  int n_vec  = 0;
  int n_bad  = 0;
  int n_desc = 0;
  int d0;
  int bm[8] = '{130, 140, 135, 145, 150, 149, 148, 147};
  logic [CW+PW+W-1:0] expd;

  // Handshakes are counted half a cycle before the edge that completes them.
  always @(negedge clk) if (o_tvalid && o_tready) n_desc++;

  function automatic logic [CW+PW+W-1:0] desc(input int idx, input int ph, input int m);
    return {CW'(idx), PW'(ph), W'(m)};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int m, input int ph, input bit lst);
    vec_t v;
    v.metric = W'(m); v.phase = PW'(ph); v.last = lst; v.ev = 1'b0; v.ed = '0;
    vq.push_back(v);
  endtask

  task automatic add_rep(input int m, input int ph, input bit lst, input int ri, input int rp, input int rm);
    vec_t v;
    v.metric = W'(m); v.phase = PW'(ph); v.last = lst; v.ev = 1'b1; v.ed = desc(ri, rp, rm);
    vq.push_back(v);
  endtask

  task automatic burst_ramp();
    for (int j = 0; j < 7; j++) add(110 + 10 * j, j, 1'b0);
    add_rep(180, 7, 1'b0, 7, 7, 180);
  endtask

  task automatic burst_b(input int ph0);
    for (int j = 0; j < 7; j++) add(bm[j], ph0 + j, 1'b0);
    add_rep(bm[7], ph0 + 7, 1'b0, 4, ph0 + 4, 150);
  endtask

  // Caller sits 2 time units after a rising edge; checks happen at the same offset.
  task automatic run_vecs(input string name);
    for (int k = 0; k < vq.size(); k++) begin
      i_tdata  = {vq[k].phase, vq[k].metric};
      i_tlast  = vq[k].last;
      i_tvalid = 1'b1;
      @(posedge clk); #2;
      chk($sformatf("%s[%0d]", name, k),
          {15'b0, o_tvalid, (vq[k].ev ? o_tdata : 64'd0)},
          {15'b0, vq[k].ev, vq[k].ed});
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clear = 1'b0; threshold = 100; plateau_len = 8;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {13'b0, o_tvalid, i_tready, o_tlast, o_tdata}, {13'b0, 3'b011, 64'd0});
    reset = 1'b0;
    @(posedge clk); #2;

    // Basic detection
    d0 = n_desc;
    add(150, 0, 1'b0); add(200, 1, 1'b0); add(300, 2, 1'b0);
    for (int j = 0; j < 10; j++)
      if (j == 4) add_rep(250, 3 + j, 1'b0, 2, 2, 300); else add(250, 3 + j, 1'b0);
    add(50, 13, 1'b0);
    run_vecs("basic");
    chk("basic_count", 80'(n_desc - d0), 80'(1));

    // Short plateau followed by a good burst
    d0 = n_desc;
    for (int j = 0; j < 7; j++) add(150, j, 1'b0);
    add(50, 7, 1'b0);
    burst_ramp();
    add(50, 8, 1'b0);
    run_vecs("short");
    chk("short_count", 80'(n_desc - d0), 80'(1));

    // Edge hold freezes the peak at 400
    d0 = n_desc;
    plateau_len = 10;
    add(150, 0, 1'b0); add(400, 1, 1'b0);
    for (int j = 0; j < 5; j++) add(300, 2 + j, 1'b0);
    add(500, 7, 1'b0); add(300, 8, 1'b0);
    add_rep(300, 9, 1'b0, 1, 1, 400);
    add(50, 10, 1'b0);
    run_vecs("edge");
    chk("edge_count", 80'(n_desc - d0), 80'(1));

    // Retrigger suppression
    d0 = n_desc;
    plateau_len = 8;
    for (int j = 0; j < 7; j++) add(150 + 10 * j, j, 1'b0);
    add_rep(220, 7, 1'b0, 7, 7, 220);
    for (int j = 0; j < 20; j++) add(200, 8 + j, 1'b0);
    add(50, 28, 1'b0);
    burst_b(40);
    add(50, 48, 1'b0);
    run_vecs("retrig");
    chk("retrig_count", 80'(n_desc - d0), 80'(2));

    // tlast abort, then plateau_len 0 with report on a tlast sample
    d0 = n_desc;
    add(150, 0, 1'b0); add(160, 1, 1'b0); add(170, 2, 1'b0); add(180, 3, 1'b0);
    add(190, 4, 1'b1);
    add(200, 5, 1'b0); add(210, 6, 1'b0); add(220, 7, 1'b0);
    add(50, 8, 1'b0);
    run_vecs("abort");
    plateau_len = 0;
    add_rep(500, 9, 1'b1, 0, 9, 500);
    add_rep(600, 10, 1'b0, 0, 10, 600);
    add(50, 11, 1'b0);
    run_vecs("plen0");
    chk("abort_count", 80'(n_desc - d0), 80'(2));

    // Equal-to-threshold is not above
    d0 = n_desc;
    plateau_len = 2;
    add(100, 0, 1'b0); add(101, 1, 1'b0);
    add_rep(101, 2, 1'b0, 0, 1, 101);
    add(50, 3, 1'b0);
    run_vecs("thresh");
    chk("thresh_count", 80'(n_desc - d0), 80'(1));

    // Backpressure
    d0 = n_desc;
    plateau_len = 8;
    o_tready = 1'b0;
    burst_ramp();
    run_vecs("bp");
    expd = desc(7, 7, 180);
    i_tdata = {16'd8, 32'd50}; i_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk($sformatf("bp_stall[%0d]", c), {14'b0, o_tvalid, i_tready, o_tdata}, {14'b0, 2'b10, expd});
    end
    o_tready = 1'b1;
    @(posedge clk); #2;
    i_tvalid = 1'b0;
    chk("bp_release", {78'b0, o_tvalid, i_tready}, {78'b0, 2'b01});
    burst_ramp();
    add(50, 8, 1'b0);
    run_vecs("bp_resume");
    chk("bp_count", 80'(n_desc - d0), 80'(2));

    // Synchronous clear discards a pending descriptor
    d0 = n_desc;
    o_tready = 1'b0;
    burst_ramp();
    run_vecs("clr");
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    chk("clear_state", {14'b0, o_tvalid, i_tready, o_tdata}, {14'b0, 2'b01, 64'd0});
    o_tready = 1'b1;
    burst_b(0);
    add(50, 8, 1'b0);
    run_vecs("clr_after");
    chk("clr_count", 80'(n_desc - d0), 80'(1));

    // Asynchronous reset during RISE
    d0 = n_desc;
    for (int j = 0; j < 4; j++) add(150 + 10 * j, j, 1'b0);
    run_vecs("rst_rise");
    #1 reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    burst_ramp();
    add(50, 8, 1'b0);
    run_vecs("rst_rise_after");
    chk("rst_rise_count", 80'(n_desc - d0), 80'(1));

    // Asynchronous reset with a descriptor pending
    d0 = n_desc;
    o_tready = 1'b0;
    burst_b(0);
    run_vecs("rst_pend");
    #1 reset = 1'b1;
    #1;
    chk("rst_pend_state", {14'b0, o_tvalid, i_tready, o_tdata}, {14'b0, 2'b01, 64'd0});
    @(posedge clk); #2;
    reset = 1'b0;
    o_tready = 1'b1;
    burst_ramp();
    add(50, 8, 1'b0);
    run_vecs("rst_pend_after");
    chk("rst_pend_count", 80'(n_desc - d0), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
